decoder_3to8_shift: RTL and testbench
=====================================

Name: decoder_3to8_shift

Overview:
- Binary-to-one-hot decoder: a 3-bit code selects exactly one of 8 output lines, gated by an enable.
- Decode is a left shift of a single 1 by the input code; combinational output with zero latency.
- A registered copy of the decode and its enable qualifier is provided for downstream synchronous consumers.
- Sits as a leaf select/address-decode block feeding chip-selects or one-hot mux controls.

Parameters:
- IN_W, 3, width of the select code.
- OUT_W, 8 (2**IN_W), width of the one-hot output; fixed relation OUT_W = 2**IN_W, not independently overridable.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  asynchronous, active-high reset; clears registered outputs.
- en  input  1  decode enable; 0 forces all outputs low.
- in  input  IN_W (3)  binary select code, bit 2 = MSB.
- out  output  OUT_W (8)  combinational one-hot decode.
- out_q  output  OUT_W (8)  registered copy of out.
- valid_q  output  1  registered copy of en, qualifies out_q.

Behaviour:
- Combinational path: out = en ? (1 << in) : 0, evaluated continuously with no clock dependency; responds within the same delta/settle time as input change.
- en=1: exactly one bit high, out[in]=1, all others 0 (in=0 -> 8'b0000_0001, in=7 -> 8'b1000_0000).
- en=0: out = 8'b0000_0000 regardless of in.
- Shift width: the 1 is sized to OUT_W before shifting; no truncation or wrap for any legal in (0..7); all 3-bit codes are legal, no out-of-range case exists.
- X/Z on in or en: out is not required to be defined; no error flag.
- Registered path: on each rising clk edge with rst=0, out_q <= out and valid_q <= en; latency one cycle from en/in to out_q/valid_q.
- Reset: rst=1 immediately (asynchronously, without a clock edge) forces out_q = 8'h00, valid_q = 0; held while rst=1.
- The combinational out is unaffected by rst.
- Reset deassertion: registers load on the first rising clk edge after rst falls.
- Reset mid-operation: any in-flight registered value is discarded; no recovery state.
- Invariant: out and out_q are always either all-zero or one-hot (popcount <= 1); out_q is nonzero only when valid_q=1.
- No internal state besides out_q and valid_q; no FSM.

Test Plan:
- en=0, in=3'b101 then 3'b010, sample after 1 time unit -> out=8'b0000_0000 both times.
- en=1, sweep in=0..7 -> out=8'b0000_0001, 0000_0010, 0000_0100, 0000_1000, 0001_0000, 0010_0000, 0100_0000, 1000_0000; popcount=1 each.
- en=1, 20 random in values from 0..7 -> out == (1 << in) every sample; en toggled to 0 mid-sequence -> out=0 immediately.
- Clocked: rst=1 then released, en=1, in=6 -> before edge out_q=8'h00, valid_q=0; after first rising edge out_q=8'b0100_0000, valid_q=1.
- Assert rst asynchronously between edges while out_q=8'b0000_1000 -> out_q=8'h00, valid_q=0 without a clock edge; out still shows combinational decode.
- en=0 clocked for one cycle after valid output -> next edge out_q=8'h00, valid_q=0.

Source files
------------

// File: rtl/decoder_3to8_shift.sv
`default_nettype none
// ============================================================================
// decoder_3to8_shift : binary-to-one-hot decoder (sized-1 left shift) gated
//                      by an enable, plus a registered copy and qualifier.
// Revision 1.0
// ============================================================================
module decoder_3to8_shift #(
  parameter  int IN_W  = 3,
  localparam int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] out_q,
  output logic             valid_q
);

  // The 1 is sized to the full output width before shifting, so every code
  // 0..OUT_W-1 lands on its own line with no truncation.
  localparam logic [OUT_W-1:0] c_one = {{(OUT_W-1){1'b0}}, 1'b1};

  logic [OUT_W-1:0] out_d;

  always_comb begin
    out_d = '0;
    if (en) begin
      out_d = c_one << in;
    end
  end

  assign out = out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= en;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_3to8_shift.sv
`default_nettype none
// ============================================================================
// tb_decoder_3to8_shift : directed self-checking bench for decoder_3to8_shift.
// Revision 1.0
// ============================================================================
module tb_decoder_3to8_shift;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] in;
  logic [7:0] out;
  logic [7:0] out_q;
  logic       valid_q;

  int n_vec;
  int n_err;

  decoder_3to8_shift #(.IN_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (in),
    .out     (out),
    .out_q   (out_q),
    .valid_q (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  logic [7:0] sweep_exp [8];
  logic [7:0] exp_v;

  initial begin
    n_vec = 0;
    n_err = 0;
    sweep_exp[0] = 8'b0000_0001;
    sweep_exp[1] = 8'b0000_0010;
    sweep_exp[2] = 8'b0000_0100;
    sweep_exp[3] = 8'b0000_1000;
    sweep_exp[4] = 8'b0001_0000;
    sweep_exp[5] = 8'b0010_0000;
    sweep_exp[6] = 8'b0100_0000;
    sweep_exp[7] = 8'b1000_0000;

    rst = 1'b1;
    en  = 1'b0;
    in  = 3'd0;
    #1;
    chk("reset out_q", out_q, 8'h00);
    chk("reset valid_q", {7'd0, valid_q}, 8'h00);

    // Disabled decode ignores the code
    in = 3'b101; #1;
    chk("en0 in5", out, 8'h00);
    in = 3'b010; #1;
    chk("en0 in2", out, 8'h00);

    // Full sweep; combinational path works while the registers sit in reset
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i); #1;
      chk($sformatf("sweep in%0d", i), out, sweep_exp[i]);
      chk($sformatf("popcount in%0d", i), 8'($countones(out)), 8'd1);
    end
    chk("out_q held in reset", out_q, 8'h00);

    for (int k = 0; k < 20; k++) begin
      in = 3'($urandom_range(0, 7));
      if (k == 10) begin
        en = 1'b0; #1;
        chk("rand en drop", out, 8'h00);
        en = 1'b1;
      end
      #1;
      exp_v = sweep_exp[in];
      chk($sformatf("rand %0d", k), out, exp_v);
    end

    // Release reset between edges, then first load
    @(negedge clk);
    en  = 1'b1;
    in  = 3'd6;
    rst = 1'b0;
    #1;
    chk("pre-edge out_q", out_q, 8'h00);
    chk("pre-edge valid_q", {7'd0, valid_q}, 8'h00);
    @(posedge clk); #1;
    chk("first edge out_q", out_q, 8'b0100_0000);
    chk("first edge valid_q", {7'd0, valid_q}, 8'h01);

    @(negedge clk);
    in = 3'd3;
    @(posedge clk); #1;
    chk("load in3 out_q", out_q, 8'b0000_1000);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_q", out_q, 8'h00);
    chk("async rst valid_q", {7'd0, valid_q}, 8'h00);
    chk("async rst out", out, 8'b0000_1000);
    @(posedge clk); #1;
    chk("rst held out_q", out_q, 8'h00);
    chk("rst held valid_q", {7'd0, valid_q}, 8'h00);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reload out_q", out_q, 8'b0000_1000);
    chk("reload valid_q", {7'd0, valid_q}, 8'h01);

    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk("en0 clocked out_q", out_q, 8'h00);
    chk("en0 clocked valid_q", {7'd0, valid_q}, 8'h00);

    @(negedge clk);
    en = 1'b1;
    in = 3'd7;
    @(posedge clk); #1;
    chk("in7 out_q", out_q, 8'b1000_0000);
    chk("in7 valid_q", {7'd0, valid_q}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
